// File: rtl/median_result_sink.sv
// median_result_sink
// Output side of the median filter. Packs four median lanes into one RAM word,
// counts the words of a frame, flags out-of-range addresses, and once the frame
// is complete lets the host read it back with one cycle of latency.
module median_result_sink #(
    parameter int PIXEL_DATA_WIDTH = 8,
    parameter int MEM_DATA_WIDTH   = 32,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int FRAME_WORDS      = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel1,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel2,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel3,
    input  logic [PIXEL_DATA_WIDTH-1:0] pixel4,
    input  logic [MEM_ADDR_WIDTH-1:0]   waddr,
    input  logic                        rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0]   rd_addr,
    output logic [MEM_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_valid,
    output logic                        busy,
    output logic                        frame_done,
    output logic [MEM_ADDR_WIDTH:0]     wr_count,
    output logic                        err_addr
);

    localparam int NUM_LANES = 4;
    localparam int RAM_DEPTH = 1 << MEM_ADDR_WIDTH;

    // Frame length in the counter's width; one extra bit so a full-depth frame
    // does not wrap back to zero.
    localparam logic [MEM_ADDR_WIDTH:0] FRAME_WORDS_W = (MEM_ADDR_WIDTH + 1)'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [MEM_ADDR_WIDTH:0]     wr_count_q, wr_count_d;
    logic                        err_addr_q, err_addr_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [MEM_DATA_WIDTH-1:0]   rd_data_q;

    logic [PIXEL_DATA_WIDTH-1:0] lane [NUM_LANES];
    logic [MEM_DATA_WIDTH-1:0]   word;
    logic                        addr_in_frame;
    logic                        wr_en;
    logic                        rd_fire;

    // Output RAM; contents survive reset on purpose.
    logic [MEM_DATA_WIDTH-1:0]   ram_q [RAM_DEPTH];

    assign lane[0] = pixel1;
    assign lane[1] = pixel2;
    assign lane[2] = pixel3;
    assign lane[3] = pixel4;

    // Lane 1 lands in the most significant byte, lane 4 in the least.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_pack
            assign word[MEM_DATA_WIDTH-1-gi*PIXEL_DATA_WIDTH -: PIXEL_DATA_WIDTH] = lane[gi];
        end
    endgenerate

    assign addr_in_frame = ({1'b0, waddr} < FRAME_WORDS_W);
    assign wr_en         = (state_q == ST_CAPTURE) && in_valid && addr_in_frame;
    // A start in DONE takes priority: the frame is re-armed and the read dropped.
    assign rd_fire       = (state_q == ST_DONE) && rd_en && !start;

    // Next-state, frame counter, sticky error and read-valid decode.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        err_addr_d = err_addr_q;
        rd_valid_d = rd_fire;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_CAPTURE;
                    wr_count_d = '0;
                    err_addr_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                // start is deliberately ignored while a frame is in flight.
                if (in_valid) begin
                    if (addr_in_frame) begin
                        wr_count_d = wr_count_q + 1'b1;
                        if (wr_count_q + 1'b1 == FRAME_WORDS_W) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        err_addr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            err_addr_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            err_addr_q <= err_addr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // RAM write port; only accepted in-frame results reach the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[waddr] <= word;
        end
    end

    // Registered RAM read; rd_data holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= ram_q[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q == ST_CAPTURE);
    assign frame_done = (state_q == ST_DONE);
    assign wr_count   = wr_count_q;
    assign err_addr   = err_addr_q;

endmodule
